// File: rtl/maple_rx_datapath.sv
// Maple Bus receive datapath: turns SDCKA/SDCKB strobes into stream words, holding one
// word back so the frame's final word carries TLAST, and watches for the end-of-frame pattern.
module maple_rx_datapath #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    enable,
  input  logic                    sdcka_data,
  input  logic                    sdcka_posedge,
  input  logic                    sdcka_negedge,
  input  logic                    sdckb_data,
  input  logic                    sdckb_posedge,
  input  logic                    sdckb_negedge,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic                    m_tvalid,
  output logic [DATA_WIDTH/8-1:0] m_tstrb,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tlast,
  output logic                    end_frame,
  output logic                    end_frame_error
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, ALOW} end_state_e;

  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  word_vld_q, word_vld_d;
  logic [DATA_WIDTH-1:0] pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  end_state_e            end_state_q;
  logic [2:0]            bcnt_q, bcnt_d;
  logic                  end_frame_q, end_error_q;

  // Both negedges in one cycle shift two bits, A-side sample first.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    word_d     = word_q;
    word_vld_d = 1'b0;
    if (!enable) begin
      bit_cnt_d = '0;
    end else begin
      if (sdcka_negedge) begin
        shift_d = {shift_d[DATA_WIDTH-2:0], sdckb_data};
        if (bit_cnt_d == LAST_BIT) begin
          word_d     = shift_d;
          word_vld_d = 1'b1;
          bit_cnt_d  = '0;
        end else begin
          bit_cnt_d = bit_cnt_d + CW'(1);
        end
      end
      if (sdckb_negedge) begin
        shift_d = {shift_d[DATA_WIDTH-2:0], sdcka_data};
        if (bit_cnt_d == LAST_BIT) begin
          word_d     = shift_d;
          word_vld_d = 1'b1;
          bit_cnt_d  = '0;
        end else begin
          bit_cnt_d = bit_cnt_d + CW'(1);
        end
      end
    end
  end

  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    tdata_d    = tdata_q;
    tvalid_d   = 1'b0;
    tlast_d    = 1'b0;
    if (word_vld_q && enable) begin
      if (pend_vld_q) begin
        tvalid_d = 1'b1;
        tdata_d  = pend_q;
      end
      pend_d     = word_q;
      pend_vld_d = 1'b1;
    end else if (!enable && pend_vld_q) begin
      // Frame closed: the held word is the last one.
      tvalid_d   = 1'b1;
      tlast_d    = 1'b1;
      tdata_d    = pend_q;
      pend_vld_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
    end
  end

  // B-edge count while A is low, saturating at 4.
  always_comb begin
    bcnt_d = bcnt_q;
    if ((sdckb_posedge || sdckb_negedge) && (bcnt_q != 3'd4)) bcnt_d = bcnt_q + 3'd1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      end_state_q <= IDLE;
      bcnt_q      <= '0;
      end_frame_q <= 1'b0;
      end_error_q <= 1'b0;
    end else begin
      end_frame_q <= 1'b0;
      end_error_q <= 1'b0;
      if (sdcka_negedge) begin
        end_state_q <= sdckb_data ? ALOW : IDLE;
        bcnt_q      <= '0;
      end else if (end_state_q == ALOW) begin
        bcnt_q <= bcnt_d;
        if (sdcka_posedge) begin
          end_state_q <= IDLE;
          end_frame_q <= (bcnt_d == 3'd3) && !sdckb_data;
          end_error_q <= (bcnt_d == 3'd1) || (bcnt_d == 3'd2) ||
                         ((bcnt_d == 3'd3) && sdckb_data);
        end
      end
    end
  end

  assign m_tdata         = tdata_q;
  assign m_tvalid        = tvalid_q;
  assign m_tlast         = tlast_q;
  assign m_tstrb         = '1;
  assign m_tkeep         = '1;
  assign end_frame       = end_frame_q;
  assign end_frame_error = end_error_q;
endmodule

// File: tb/tb_maple_rx_datapath.sv
// Randomized and directed bench for maple_rx_datapath against a queue-based frame model.
module tb_maple_rx_datapath;
  localparam int DW = 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable = 1'b0;
  logic          sdcka_data = 1'b1, sdcka_posedge = 1'b0, sdcka_negedge = 1'b0;
  logic          sdckb_data = 1'b1, sdckb_posedge = 1'b0, sdckb_negedge = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast, end_frame, end_frame_error;
  logic [DW/8-1:0] m_tstrb, m_tkeep;

  always #5 aclk = ~aclk;

  maple_rx_datapath #(.DATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .sdcka_data(sdcka_data), .sdcka_posedge(sdcka_posedge), .sdcka_negedge(sdcka_negedge),
    .sdckb_data(sdckb_data), .sdckb_posedge(sdckb_posedge), .sdckb_negedge(sdckb_negedge),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tstrb(m_tstrb), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .end_frame(end_frame), .end_frame_error(end_frame_error)
  );

  int vectors = 0, miscompares = 0;

  // Model: received bits of the current frame, words completed last cycle, held-back word.
  bit            mbits[$];
  logic [DW-1:0] inflight[$];
  logic [DW-1:0] pend[$];
  bit            a_low = 1'b0;
  int            bedges = 0;
  logic          e_valid = 1'b0, e_last = 1'b0, e_end = 1'b0, e_err = 1'b0;
  logic [DW-1:0] e_data = '0;

  function automatic void take(bit b);
    logic [DW-1:0] w;
    mbits.push_back(b);
    if (mbits.size() == DW) begin
      w = '0;
      foreach (mbits[i]) w = {w[DW-2:0], mbits[i]};
      inflight.push_back(w);
      mbits.delete();
    end
  endfunction

  always @(posedge aclk) begin
    if (!aresetn) begin
      mbits.delete(); inflight.delete(); pend.delete();
      a_low = 1'b0; bedges = 0;
      e_valid = 1'b0; e_last = 1'b0; e_end = 1'b0; e_err = 1'b0; e_data = '0;
    end else begin
      e_valid = 1'b0; e_last = 1'b0; e_end = 1'b0; e_err = 1'b0;
      if (inflight.size() != 0 && enable) begin
        if (pend.size() != 0) begin e_valid = 1'b1; e_data = pend.pop_front(); end
        pend.push_back(inflight[0]);
      end else if (!enable && pend.size() != 0) begin
        e_valid = 1'b1; e_last = 1'b1; e_data = pend.pop_front();
      end
      inflight.delete();
      if (enable) begin
        if (sdcka_negedge) take(sdckb_data);
        if (sdckb_negedge) take(sdcka_data);
      end else begin
        mbits.delete();
      end
      if (sdcka_negedge) begin
        a_low = sdckb_data; bedges = 0;
      end else if (a_low) begin
        if ((sdckb_posedge || sdckb_negedge) && bedges < 4) bedges++;
        if (sdcka_posedge) begin
          a_low = 1'b0;
          if (bedges == 3 && !sdckb_data) e_end = 1'b1;
          else if (bedges >= 1 && bedges <= 3) e_err = 1'b1;
        end
      end
    end
  end

  logic [DW:0] beats[$];
  int n_end = 0, n_err = 0;

  always @(negedge aclk) begin
    vectors++;
    if (m_tvalid !== e_valid || m_tlast !== e_last || m_tdata !== e_data ||
        end_frame !== e_end || end_frame_error !== e_err || m_tstrb !== '1 || m_tkeep !== '1) begin
      miscompares++;
      $display("FAIL cycle_cmp t=%0t got v=%b l=%b d=%h ef=%b ee=%b strb=%h keep=%h, expected v=%b l=%b d=%h ef=%b ee=%b strb/keep all ones",
               $time, m_tvalid, m_tlast, m_tdata, end_frame, end_frame_error, m_tstrb, m_tkeep,
               e_valid, e_last, e_data, e_end, e_err);
    end
    if (m_tvalid === 1'b1) beats.push_back({m_tlast, m_tdata});
    if (end_frame === 1'b1) n_end++;
    if (end_frame_error === 1'b1) n_err++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int beat_at(int i);
    return (i < beats.size()) ? int'(beats[i]) : -1;
  endfunction

  task automatic step(input logic na, input logic nb);
    sdcka_posedge = na & ~sdcka_data; sdcka_negedge = ~na & sdcka_data;
    sdckb_posedge = nb & ~sdckb_data; sdckb_negedge = ~nb & sdckb_data;
    sdcka_data = na; sdckb_data = nb;
    @(posedge aclk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(sdcka_data, sdckb_data);
  endtask

  bit ph = 1'b0;
  // Alternating phases; the data line only ever rises, so the only falls are clock falls.
  task automatic send_bit(input logic d);
    if (!ph) begin step(1'b1, d); step(1'b0, d); end
    else     begin step(d, 1'b1); step(d, 1'b0); end
    ph = ~ph;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic prep();
    step(1'b1, 1'b0);
    ph = 1'b0;
  endtask

  task automatic end_pat();
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b1);
  endtask

  initial begin
    int ne, nr, n;
    // Reset held for three cycles
    repeat (3) step(1'b1, 1'b1);
    chk("rst_tvalid", int'(m_tvalid), 0);
    chk("rst_tlast", int'(m_tlast), 0);
    chk("rst_tdata", int'(m_tdata), 0);
    chk("rst_end_frame", int'(end_frame), 0);
    chk("rst_end_error", int'(end_frame_error), 0);
    chk("rst_tstrb", int'(m_tstrb), 1);
    chk("rst_tkeep", int'(m_tkeep), 1);
    aresetn = 1'b1;
    idle(2);

    // Two bytes then end pattern
    beats.delete(); ne = n_end;
    prep(); enable = 1'b1;
    send_byte(8'hA5); send_byte(8'h3C);
    end_pat();
    enable = 1'b0; idle(3);
    chk("two_byte_count", beats.size(), 2);
    chk("two_byte_beat0", beat_at(0), 'h0A5);
    chk("two_byte_beat1", beat_at(1), 'h13C);
    chk("two_byte_end", n_end - ne, 1);

    // Single byte frame
    beats.delete();
    prep(); enable = 1'b1;
    send_byte(8'h81); idle(2);
    enable = 1'b0; idle(3);
    chk("one_byte_count", beats.size(), 1);
    chk("one_byte_beat0", beat_at(0), 'h181);

    // Disabled frame: no beats, end pattern still seen
    beats.delete(); ne = n_end;
    prep();
    send_byte(8'h55); send_byte(8'hAA);
    end_pat(); idle(3);
    chk("disabled_beats", beats.size(), 0);
    chk("disabled_end", n_end - ne, 1);

    // Short and over-long B activity while A is low
    ne = n_end; nr = n_err;
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b1); idle(2);
    chk("one_edge_err", n_err - nr, 1);
    chk("one_edge_end", n_end - ne, 0);
    ne = n_end; nr = n_err;
    step(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, ~sdckb_data);
    step(1'b1, 1'b1); idle(2);
    chk("eight_edge_err", n_err - nr, 0);
    chk("eight_edge_end", n_end - ne, 0);

    // Reset mid-word, then a clean byte
    beats.delete();
    prep(); enable = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    aresetn = 1'b0; enable = 1'b0; idle(2);
    aresetn = 1'b1; prep(); enable = 1'b1;
    send_byte(8'hFF); idle(2);
    enable = 1'b0; idle(3);
    chk("rst_mid_count", beats.size(), 1);
    chk("rst_mid_beat0", beat_at(0), 'h1FF);

    // Random protocol frames
    for (int f = 0; f < 40; f++) begin
      enable = 1'b0; prep(); enable = 1'b1;
      n = $urandom_range(0, 40);
      for (int k = 0; k < n; k++) send_bit(1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) end_pat();
      enable = 1'b0; idle($urandom_range(1, 3));
    end

    // Random line levels, enable and occasional reset
    for (int c = 0; c < 2000; c++) begin
      aresetn = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      step(($urandom_range(0, 2) == 0) ? ~sdcka_data : sdcka_data,
           ($urandom_range(0, 2) == 0) ? ~sdckb_data : sdckb_data);
    end
    aresetn = 1'b1; enable = 1'b0; idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
